scan_imem_loader: RTL

- Target-side responder for the serial scan-chain IMEM load/readback protocol. The bench or an external debugger is the initiator.
- Deserializes the scan header and data words arriving on scan_in, and drives single-cycle writes into the instruction memory port.
- In read mode, fetches IMEM words and serializes them LSB-first on scan_out.
- Holds the core in stall while a scan transaction is active. Sits between the chip-level scan pins and the IMEM second port in rv_uart_top.

---
 rtl/scan_imem_loader.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/scan_imem_loader.sv
// Scan-chain responder: deserializes a 64-bit header plus data words into IMEM writes, or streams IMEM words out on scan_out.
// Define SCAN_CHECKSUM_EN to drive scan_chk with a running XOR of every written word; otherwise scan_chk is 0.
module scan_imem_loader #(
    parameter int ADDR_W    = 32,
    parameter int ADDR_STEP = 4,
    parameter int COUNT_W   = 31
) (
    input  logic              clk,
    input  logic              Rst,
    input  logic              scan_en,
    input  logic              scan_in,
    output logic              scan_out,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              core_stall,
    output logic              busy,
    output logic [31:0]       scan_chk
);
    typedef enum logic [2:0] {IDLE, HDR, DATA_WR, RD_FETCH, RD_SHIFT, DONE} state_t;

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(ADDR_STEP);

    state_t             state, state_next;
    logic [5:0]         bit_cnt, bit_cnt_next;
    logic [62:0]        hdr, hdr_next;
    logic [30:0]        word, word_next;
    logic [30:0]        shreg, shreg_next;
    logic [COUNT_W-1:0] count, count_next;
    logic [ADDR_W-1:0]  addr, addr_next, mem_addr_next;
    logic [31:0]        mem_wdata_next;
    logic               scan_out_next, mem_we_next, mem_re_next;
    logic               busy_next, core_stall_next;

    // The bit arriving this cycle completes the header/word, so decisions use it directly.
    logic [63:0]        hdr_full;
    logic [31:0]        word_full;
    logic               hdr_op;
    logic [COUNT_W-1:0] hdr_n;
    logic [ADDR_W-1:0]  hdr_a;

    assign hdr_full  = {scan_in, hdr};
    assign word_full = {scan_in, word};
    assign hdr_op    = hdr_full[0];
    assign hdr_n     = hdr_full[1 +: COUNT_W];
    assign hdr_a     = hdr_full[32 +: ADDR_W];

    always_comb begin
        state_next     = state;
        bit_cnt_next   = bit_cnt;
        hdr_next       = hdr;
        word_next      = word;
        shreg_next     = shreg;
        count_next     = count;
        addr_next      = addr;
        mem_addr_next  = mem_addr;
        mem_wdata_next = mem_wdata;
        scan_out_next  = 1'b0;
        mem_we_next    = 1'b0;
        mem_re_next    = 1'b0;

        if (!scan_en) begin
            state_next   = IDLE;
            bit_cnt_next = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    hdr_next     = hdr_full[63:1];
                    bit_cnt_next = 6'd1;
                    state_next   = HDR;
                end
                HDR: begin
                    hdr_next = hdr_full[63:1];
                    if (bit_cnt == 6'd63) begin
                        bit_cnt_next = '0;
                        count_next   = hdr_n;
                        addr_next    = hdr_a;
                        if (hdr_n == '0) begin
                            state_next = DONE;
                        end else if (hdr_op) begin
                            state_next = DATA_WR;
                        end else begin
                            state_next    = RD_FETCH;
                            mem_re_next   = 1'b1;
                            mem_addr_next = hdr_a;
                            addr_next     = hdr_a + STEP;
                        end
                    end else begin
                        bit_cnt_next = bit_cnt + 6'd1;
                    end
                end
                DATA_WR: begin
                    word_next = word_full[31:1];
                    if (bit_cnt == 6'd31) begin
                        mem_we_next    = 1'b1;
                        mem_addr_next  = addr;
                        mem_wdata_next = word_full;
                        addr_next      = addr + STEP;
                        count_next     = count - COUNT_W'(1);
                        bit_cnt_next   = '0;
                        if (count == COUNT_W'(1)) state_next = DONE;
                    end else begin
                        bit_cnt_next = bit_cnt + 6'd1;
                    end
                end
                RD_FETCH: begin
                    // First cycle: strobe is out. Second cycle: read data is valid and gets loaded.
                    if (bit_cnt == '0) begin
                        bit_cnt_next = 6'd1;
                    end else begin
                        shreg_next    = mem_rdata[31:1];
                        scan_out_next = mem_rdata[0];
                        bit_cnt_next  = '0;
                        state_next    = RD_SHIFT;
                    end
                end
                RD_SHIFT: begin
                    if (bit_cnt == 6'd31) begin
                        count_next   = count - COUNT_W'(1);
                        bit_cnt_next = '0;
                        if (count == COUNT_W'(1)) begin
                            state_next = DONE;
                        end else begin
                            shreg_next    = mem_rdata[31:1];
                            scan_out_next = mem_rdata[0];
                        end
                    end else begin
                        shreg_next    = {1'b0, shreg[30:1]};
                        scan_out_next = shreg[0];
                        bit_cnt_next  = bit_cnt + 6'd1;
                        // Prefetch so the next word's data lands exactly as bit 31 leaves.
                        if (bit_cnt == 6'd29 && count != COUNT_W'(1)) begin
                            mem_re_next   = 1'b1;
                            mem_addr_next = addr;
                            addr_next     = addr + STEP;
                        end
                    end
                end
                DONE:    state_next = DONE;
                default: state_next = IDLE;
            endcase
        end

        busy_next       = (state_next == HDR) || (state_next == DATA_WR) ||
                          (state_next == RD_FETCH) || (state_next == RD_SHIFT);
        core_stall_next = scan_en || (state_next != IDLE);
    end

    // NOTE: every register takes its next value with <=, so all of them update together at the edge.
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            hdr        <= '0;
            word       <= '0;
            shreg      <= '0;
            count      <= '0;
            addr       <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            scan_out   <= 1'b0;
            mem_we     <= 1'b0;
            mem_re     <= 1'b0;
            busy       <= 1'b0;
            core_stall <= 1'b0;
        end else begin
            state      <= state_next;
            bit_cnt    <= bit_cnt_next;
            hdr        <= hdr_next;
            word       <= word_next;
            shreg      <= shreg_next;
            count      <= count_next;
            addr       <= addr_next;
            mem_addr   <= mem_addr_next;
            mem_wdata  <= mem_wdata_next;
            scan_out   <= scan_out_next;
            mem_we     <= mem_we_next;
            mem_re     <= mem_re_next;
            busy       <= busy_next;
            core_stall <= core_stall_next;
        end
    end

`ifdef SCAN_CHECKSUM_EN
    logic [31:0] chk;

    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            chk <= '0;
        end else if (state == IDLE && scan_en) begin
            chk <= '0;
        end else if (mem_we_next) begin
            chk <= chk ^ mem_wdata_next;
        end
    end

    assign scan_chk = chk;
`else
    assign scan_chk = '0;
`endif

endmodule
